// File: rtl/rs_syndrome_calc_if.sv
// Symbol-stream input and parallel syndrome output bundle for the RS(255,247)
// syndrome stage.
interface rs_syndrome_calc_if;
    logic        din_val;
    logic        din_sop;
    logic        din_eop;
    logic [7:0]  din;
    logic        synd_val;
    logic [63:0] synd;
    logic        synd_nz;
    logic        len_err;
    logic        blk_abort;

    modport master (
        output din_val, din_sop, din_eop, din,
        input  synd_val, synd, synd_nz, len_err, blk_abort
    );

    modport slave (
        input  din_val, din_sop, din_eop, din,
        output synd_val, synd, synd_nz, len_err, blk_abort
    );
endinterface

// File: rtl/rs_syndrome_calc.sv
// RS(255,247) syndrome calculator over GF(256)/0x11D: Horner evaluation of the
// received word at alpha^1..alpha^8, one lane per syndrome.
module rs_synd_lane #(
    parameter int J = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       load,
    input  logic [7:0] din,
    output logic [7:0] acc_nxt
);
    logic [7:0] acc_q;
    logic [7:0] acc_mul;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
    endfunction

    // Multiply by alpha^J as J chained constant xtime stages (pure xor network).
    always_comb begin
        acc_mul = acc_q;
        for (int k = 0; k < J; k++) acc_mul = xtime(acc_mul);
    end

    assign acc_nxt = load ? din : (acc_mul ^ din);

    always_ff @(posedge clk) begin
        if (!rst_n)  acc_q <= '0;
        else if (en) acc_q <= acc_nxt;
    end
endmodule

module rs_syndrome_calc #(
    parameter int N     = 255,
    parameter int NSYND = 8
) (
    input logic               clk,
    input logic               rst_n,
    rs_syndrome_calc_if.slave bus
);
    typedef enum logic {IDLE, ACCUM} state_t;

    localparam logic [8:0] N_CNT = 9'(N);

    state_t                  state_q, state_d;
    logic [8:0]              cnt_q, cnt_nxt;
    logic                    acc_en, acc_load, done, abort;
    logic [NSYND-1:0][7:0]   acc_nxt;

    for (genvar i = 0; i < NSYND; i++) begin : g_lane
        rs_synd_lane #(.J(i + 1)) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (acc_en),
            .load    (acc_load),
            .din     (bus.din),
            .acc_nxt (acc_nxt[i])
        );
    end

    // A sop seen while a block is open restarts it; sop+eop is a complete 1-symbol block.
    always_comb begin
        state_d  = state_q;
        acc_en   = 1'b0;
        acc_load = 1'b0;
        done     = 1'b0;
        abort    = 1'b0;
        if (bus.din_val) begin
            case (state_q)
                IDLE: begin
                    if (bus.din_sop) begin
                        acc_en   = 1'b1;
                        acc_load = 1'b1;
                        if (bus.din_eop) done = 1'b1;
                        else             state_d = ACCUM;
                    end
                end
                ACCUM: begin
                    acc_en   = 1'b1;
                    acc_load = bus.din_sop;
                    abort    = bus.din_sop;
                    if (bus.din_eop) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign cnt_nxt = acc_load ? 9'd1 : ((&cnt_q) ? cnt_q : cnt_q + 9'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            bus.synd_val  <= 1'b0;
            bus.synd      <= '0;
            bus.synd_nz   <= 1'b0;
            bus.len_err   <= 1'b0;
            bus.blk_abort <= 1'b0;
        end else begin
            state_q       <= state_d;
            bus.synd_val  <= done;
            bus.blk_abort <= abort;
            if (acc_en) cnt_q <= cnt_nxt;
            if (done) begin
                bus.synd    <= acc_nxt;
                bus.synd_nz <= |acc_nxt;
                bus.len_err <= (cnt_nxt != N_CNT);
            end
        end
    end
endmodule
